turnstile_fsm: RTL and testbench
================================

Name: turnstile_fsm

Overview:
Coin-operated turnstile controller with an accepted-coin counter. A rising edge on the coin input unlocks the turnstile. A rising edge on the push input (a passage) re-locks it. The block sits at the boundary between debounced panel inputs and status/display logic, and drives mutually exclusive locked/unlocked indications plus a running coin count.

Parameters:
CNT_W, 8, width of counter_o (coin count register).

Ports:
clk_i  input  1  system clock; all state updates on its rising edge.
rst_ni  input  1  asynchronous, active-low reset.
coin_i  input  1  coin-inserted level, synchronous to clk_i; each 0->1 transition is one coin.
push_i  input  1  arm-pushed level, synchronous to clk_i; each 0->1 transition is one passage attempt.
locked_o  output  1  high while in LOCKED.
unlocked_o  output  1  high while in UNLOCKED; always the complement of locked_o.
counter_o  output  CNT_W  number of coins accepted since reset, modulo 2^CNT_W.

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- Reset (rst_ni=0, immediate, independent of clk_i):
  - state = LOCKED, so locked_o=1 and unlocked_o=0.
  - counter_o = 0.
  - Edge-detect history registers coin_q and push_q = 0.
- Reset release: a coin_i or push_i already high at the first active edge counts as a rising edge, because the history register is 0.
- Edge detection:
  - coin_rise = coin_i & ~coin_q; push_rise = push_i & ~push_q.
  - coin_q and push_q sample their inputs every clock.
  - A held-high level produces exactly one event.
- Inputs are treated as already synchronous and debounced. There are no synchronizers inside the block.
- Latency: an input seen high at clock edge k (with low at k-1) updates state and counter at edge k. Outputs are valid after edge k, i.e. zero cycles of added delay beyond the sampling edge.
- States are LOCKED and UNLOCKED (Moore outputs, decoded from the state register).
  - LOCKED + coin_rise -> UNLOCKED. This applies whether or not push_rise is also present; coin has priority.
  - LOCKED + push_rise only -> stay LOCKED (the push is blocked).
  - UNLOCKED + push_rise only -> LOCKED.
  - UNLOCKED + coin_rise only -> stay UNLOCKED (extra credit is not banked).
  - UNLOCKED + push_rise and coin_rise in the same cycle -> stay UNLOCKED. The passage consumes the old credit and the new coin grants a fresh one.
  - No event -> hold state.
- Counter:
  - Increments by 1 on every coin_rise, in any state.
  - Wraps from 2^CNT_W-1 to 0 (wrap applies with the macro undefined).
  - push_i never affects counter_o.
- Invariant: locked_o != unlocked_o at all times, including during reset.
- Reset asserted mid-operation: the block returns immediately to LOCKED with count 0, and any edge pending in that cycle is lost.

Optional Feature:
TURNSTILE_CNT_SAT_EN
- Defined: counter_o saturates at 2^CNT_W-1 (255 for the default). Further coins are still accepted and still unlock the turnstile, but the count is not changed.
- Undefined: counter wraps modulo 2^CNT_W as described above.

Decomposition:
- Package turnstile_pkg contains:
  - typedef enum logic {ST_LOCKED, ST_UNLOCKED} turnstile_state_e;
  - localparam for the reset state (ST_LOCKED).
- Sub-module rise_edge_det: one flop plus an AND gate, with ports clk_i, rst_ni, d_i, rise_o. It is instantiated twice, once for coin_i and once for push_i.
- FSM and counter live in turnstile_fsm.

Test Plan:
- Reset: hold rst_ni=0 for 100 ns with inputs toggling -> locked_o=1, unlocked_o=0, counter_o=0 throughout. Assert rst_ni=0 asynchronously between clock edges -> outputs change without waiting for a clock.
- Single coin then push: coin_i 0->1 -> next edge gives unlocked_o=1 and counter_o=1. Then push_i 0->1 -> next edge gives locked_o=1 and counter_o=1.
- Held level: coin_i held high for 10 cycles -> counter_o=1 only. push_i held high while locked -> stays LOCKED.
- Simultaneous edges:
  - From LOCKED, coin and push rise together -> UNLOCKED, count +1.
  - From UNLOCKED, both rise together -> stays UNLOCKED, count +1.
- Free-running stimulus (clk 20 ns period, coin toggling every 20 ns, push toggling every 40 ns) -> coin_rise every 2 cycles and push_rise every 4 cycles. Counter increments every 2 cycles and locked_o/unlocked_o always complementary.
- Boundary: 256 coin edges -> counter_o=0 (macro undefined) or 255 (TURNSTILE_CNT_SAT_EN defined). The turnstile still unlocks on the 257th coin in both builds.

Source files
------------

// File: rtl/turnstile_pkg.sv
// Shared types for the coin-operated turnstile controller.
// Imported by turnstile_fsm.
package turnstile_pkg;

    typedef enum logic {
        ST_LOCKED,
        ST_UNLOCKED
    } turnstile_state_e;

    localparam turnstile_state_e RST_STATE = ST_LOCKED;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: one history flop plus an AND gate.
// History clears on reset, so a level already high at release counts.
module rise_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/turnstile_fsm.sv
// Turnstile controller: coin edge unlocks, push edge re-locks, counts coins.
// Define TURNSTILE_CNT_SAT_EN to saturate the coin count instead of wrapping.
module turnstile_fsm
    import turnstile_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             coin_i,
    input  logic             push_i,
    output logic             locked_o,
    output logic             unlocked_o,
    output logic [CNT_W-1:0] counter_o
);

    turnstile_state_e state_q;
    turnstile_state_e state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             coin_rise;
    logic             push_rise;

    rise_edge_det u_coin_det (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (coin_i),
        .rise_o (coin_rise)
    );

    rise_edge_det u_push_det (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (push_i),
        .rise_o (push_rise)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_STATE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // A coin always leaves the gate unlocked, even alongside a push:
    // the push spends the old credit and the coin grants a new one.
    always_comb begin
        state_d = state_q;
        priority case (1'b1)
            coin_rise: state_d = ST_UNLOCKED;
            push_rise: state_d = ST_LOCKED;
            default:   state_d = state_q;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (coin_rise) begin
`ifdef TURNSTILE_CNT_SAT_EN
            if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
`else
            count_d = count_q + CNT_W'(1);
`endif
        end
    end

    assign locked_o   = (state_q == ST_LOCKED);
    assign unlocked_o = ~locked_o;
    assign counter_o  = count_q;

endmodule

// File: tb/tb_turnstile_fsm.sv
// Directed bench for turnstile_fsm; follows TURNSTILE_CNT_SAT_EN if defined.
// Inputs change 1 ns after the rising edge; outputs are read there too.
module tb_turnstile_fsm;

    logic       clk_i;
    logic       rst_ni;
    logic       coin_i;
    logic       push_i;
    logic       locked_o;
    logic       unlocked_o;
    logic [7:0] counter_o;

    int n_cmp;
    int n_bad;

    turnstile_fsm #(
        .CNT_W (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .coin_i     (coin_i),
        .push_i     (push_i),
        .locked_o   (locked_o),
        .unlocked_o (unlocked_o),
        .counter_o  (counter_o)
    );

    initial clk_i = 1'b0;
    always #10 clk_i = ~clk_i;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(
        input string       tag,
        input logic        exp_unl,
        input logic [31:0] exp_cnt
    );
        check({tag, ".locked"}, 32'(locked_o), 32'(!exp_unl));
        check({tag, ".unlocked"}, 32'(unlocked_o), 32'(exp_unl));
        check({tag, ".count"}, 32'(counter_o), exp_cnt);
    endtask

    logic        pc;
    logic        pp;
    logic        m_unl;
    logic [7:0]  m_cnt;
    logic [31:0] wrap_cnt;
    logic [31:0] after_cnt;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_ni = 1'b0;
        coin_i = 1'b0;
        push_i = 1'b0;

        // Reset held 100 ns with inputs toggling.
        for (int i = 0; i < 10; i++) begin
            #10;
            coin_i = ~coin_i;
            push_i = (i % 2 == 0) ? ~push_i : push_i;
            #1;
            check_out("rst_hold", 1'b0, 0);
        end
        @(negedge clk_i);
        coin_i = 1'b0;
        push_i = 1'b0;
        #3;
        rst_ni = 1'b1;
        tick();
        check_out("rel_idle", 1'b0, 0);

        // Single coin then push.
        coin_i = 1'b1;
        tick();
        check_out("coin1", 1'b1, 1);
        coin_i = 1'b0;
        push_i = 1'b1;
        tick();
        check_out("push1", 1'b0, 1);
        push_i = 1'b0;
        tick();

        // Coin held high for 10 cycles: one event only.
        coin_i = 1'b1;
        tick();
        check_out("hold_c0", 1'b1, 2);
        repeat (9) tick();
        check_out("hold_c9", 1'b1, 2);
        coin_i = 1'b0;
        tick();
        push_i = 1'b1;
        tick();
        check_out("hold_p0", 1'b0, 2);
        repeat (5) tick();
        check_out("hold_p5", 1'b0, 2);
        push_i = 1'b0;
        tick();

        // Simultaneous coin and push edges.
        coin_i = 1'b1;
        push_i = 1'b1;
        tick();
        check_out("both_lk", 1'b1, 3);
        coin_i = 1'b0;
        push_i = 1'b0;
        tick();
        coin_i = 1'b1;
        push_i = 1'b1;
        tick();
        check_out("both_ul", 1'b1, 4);
        coin_i = 1'b0;
        push_i = 1'b0;
        tick();
        push_i = 1'b1;
        tick();
        check_out("relock", 1'b0, 4);
        push_i = 1'b0;
        tick();

        // Free-running: coin toggles every cycle, push every two.
        pc    = 1'b0;
        pp    = 1'b0;
        m_unl = 1'b0;
        m_cnt = 8'd4;
        for (int i = 0; i < 24; i++) begin
            coin_i = ~coin_i;
            if (i % 2 == 1) push_i = ~push_i;
            if (coin_i && !pc) begin
                m_unl = 1'b1;
                m_cnt = m_cnt + 8'd1;
            end else if (push_i && !pp) begin
                m_unl = 1'b0;
            end
            pc = coin_i;
            pp = push_i;
            tick();
            check_out("free", m_unl, 32'(m_cnt));
            check("free.excl", 32'(locked_o ^ unlocked_o), 1);
        end
        check("free.total", 32'(counter_o), 16);
        coin_i = 1'b0;
        push_i = 1'b0;
        tick();

        // Asynchronous reset between edges from UNLOCKED.
        coin_i = 1'b1;
        tick();
        coin_i = 1'b0;
        check_out("pre_arst", 1'b1, 17);
        #4;
        rst_ni = 1'b0;
        #1;
        check_out("arst", 1'b0, 0);
        #2;
        rst_ni = 1'b1;
        tick();
        check_out("arst_rel", 1'b0, 0);

        // Boundary: 256 coin edges, then a further coin.
        repeat (255) begin
            coin_i = 1'b1;
            tick();
            coin_i = 1'b0;
            tick();
        end
        check_out("c255", 1'b1, 255);
`ifdef TURNSTILE_CNT_SAT_EN
        wrap_cnt  = 32'd255;
        after_cnt = 32'd255;
`else
        wrap_cnt  = 32'd0;
        after_cnt = 32'd1;
`endif
        coin_i = 1'b1;
        tick();
        check_out("c256", 1'b1, wrap_cnt);
        coin_i = 1'b0;
        tick();
        push_i = 1'b1;
        tick();
        check_out("c256_lk", 1'b0, wrap_cnt);
        push_i = 1'b0;
        tick();
        coin_i = 1'b1;
        tick();
        check_out("c257", 1'b1, after_cnt);
        coin_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
